// File: rtl/fsm_seq_pkg.sv
// -----------------------------------------------------------------------------
// fsm_seq_pkg
// Shared helpers for the Mealy sequence detector. These functions run only at
// elaboration. They build the prefix/failure (KMP) transition table from the
// target pattern. Pattern bits are received MSB first, so sequence position 0
// is pat[n-1] and the final bit of the pattern is pat[0].
// -----------------------------------------------------------------------------
package fsm_seq_pkg;

    localparam int MAX_PAT_W = 16;

    // Width of the state index: clog2 of the pattern length (never below 1).
    function automatic int state_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bit at sequence position i (0 = first bit received).
    function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int n, input int i);
        return pat[n-1-i];
    endfunction

    // Longest j <= max_j such that the first j pattern bits equal the last
    // j bits of hist[0 +: len].
    function automatic int longest_prefix_suffix(input logic [MAX_PAT_W-1:0] pat, input int n,
                                                 input logic [MAX_PAT_W:0] hist, input int len,
                                                 input int max_j);
        for (int j = max_j; j > 0; j--) begin
            logic ok;
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pat_bit(pat, n, i) != hist[len-j+i]) ok = 1'b0;
            end
            if (ok) return j;
        end
        return 0;
    endfunction

    // Next state from Sk after consuming bit b. A completed match lands on the
    // longest proper border (overlapping) or back on S0 (non-overlapping).
    function automatic int next_state(input logic [MAX_PAT_W-1:0] pat, input int n, input int k,
                                      input logic b, input logic overlap);
        logic [MAX_PAT_W:0] hist;
        if (k >= n) return 0;
        hist = '0;
        for (int i = 0; i < k; i++) hist[i] = pat_bit(pat, n, i);
        hist[k] = b;
        if ((k == n-1) && (b == pat_bit(pat, n, n-1))) begin
            return overlap ? longest_prefix_suffix(pat, n, hist, n, n-1) : 0;
        end
        return longest_prefix_suffix(pat, n, hist, k+1, k+1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a registered saturation flag.
//   i_clock  : clock, rising edge
//   i_reset  : synchronous active-high reset (count and flag cleared)
//   i_inc    : increment request for this cycle
//   o_count  : current count, holds at all-ones
//   o_sat    : high while o_count is all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_sat
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             sat_q;

    always_comb begin
        count_d = count_q;
        if (i_inc && !(&count_q)) count_d = count_q + 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            // Flag tracks the value being loaded, so it rises on the same edge
            // the counter reaches all-ones.
            sat_q   <= &count_d;
        end
    end

    assign o_count = count_q;
    assign o_sat   = sat_q;

endmodule

// File: rtl/fsm_mealy_seq_detect.sv
// -----------------------------------------------------------------------------
// fsm_mealy_seq_detect
// Mealy serial pattern detector with KMP failure transitions and a saturating
// match counter.
//   i_clock       : clock, rising edge
//   i_reset       : synchronous active-high reset
//   i_enable      : qualifies i_data_in; state and counter hold when low
//   i_data_in     : serial data bit, pattern received MSB first
//   o_data_out    : combinational match flag (zero latency)
//   o_match_count : registered saturating match count
//   o_count_sat   : registered flag, high while the count is all-ones
// -----------------------------------------------------------------------------
module fsm_mealy_seq_detect
    import fsm_seq_pkg::*;
#(
    parameter int                     PATTERN_WIDTH = 4,
    parameter logic [PATTERN_WIDTH-1:0] PATTERN     = 4'b1010,
    parameter bit                     OVERLAP       = 1'b1,
    parameter int                     COUNT_WIDTH   = 8
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_data_in,
    output logic                   o_data_out,
    output logic [COUNT_WIDTH-1:0] o_match_count,
    output logic                   o_count_sat
);

    localparam int              SW      = state_w(PATTERN_WIDTH);
    localparam int              NSTATES = 2**SW;
    localparam logic [SW-1:0]   S_LAST  = SW'(PATTERN_WIDTH-1);
    localparam logic [MAX_PAT_W-1:0] PAT_EXT = MAX_PAT_W'(PATTERN);

    // Transition table, fully resolved at elaboration. Index codes above
    // PATTERN_WIDTH-1 are unreachable and map to S0.
    logic [SW-1:0] nxt_tbl [NSTATES][2];

    for (genvar k = 0; k < NSTATES; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int NS = next_state(PAT_EXT, PATTERN_WIDTH, k, 1'(b), OVERLAP);
            assign nxt_tbl[k][b] = SW'(NS);
        end
    end

    logic [SW-1:0] state_q, state_d;
    logic          match;

    always_comb begin
        state_d = state_q;
        match   = 1'b0;
        if (i_enable && !i_reset) begin
            match   = (state_q == S_LAST) && (i_data_in == PATTERN[0]);
            state_d = nxt_tbl[state_q][i_data_in];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= '0;
        else         state_q <= state_d;
    end

    assign o_data_out = match;

    sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_sat_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (match),
        .o_count (o_match_count),
        .o_sat   (o_count_sat)
    );

endmodule

// File: tb/tb_fsm_mealy_seq_detect.sv
// -----------------------------------------------------------------------------
// tb_fsm_mealy_seq_detect
// Three detectors for pattern 1010 share one input stream:
//   A: overlapping, 8-bit counter
//   B: non-overlapping, 8-bit counter
//   C: overlapping, 2-bit counter (saturates)
// The stimulus pushes hand-computed expectations; a monitor on the falling
// edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_fsm_mealy_seq_detect;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic din = 1'b0;

    logic       a_out, b_out, c_out;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;
    logic       a_sat, b_sat, c_sat;

    always #5 clk = ~clk;

    fsm_mealy_seq_detect #(.PATTERN_WIDTH(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .COUNT_WIDTH(8)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_data_in(din),
        .o_data_out(a_out), .o_match_count(a_cnt), .o_count_sat(a_sat));

    fsm_mealy_seq_detect #(.PATTERN_WIDTH(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .COUNT_WIDTH(8)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_data_in(din),
        .o_data_out(b_out), .o_match_count(b_cnt), .o_count_sat(b_sat));

    fsm_mealy_seq_detect #(.PATTERN_WIDTH(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .COUNT_WIDTH(2)) dut_c (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_data_in(din),
        .o_data_out(c_out), .o_match_count(c_cnt), .o_count_sat(c_sat));

    // Expected outputs for one cycle: match flags for the current inputs and
    // counter values as registered before this cycle's rising edge.
    typedef struct {
        int   step;
        logic oa, ob, oc;
        int   ca, cb, cc;
        logic sc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic check(input string name, input int step, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e_mon = sb_q.pop_front();
            check("a_data_out", e_mon.step, int'(a_out), int'(e_mon.oa));
            check("b_data_out", e_mon.step, int'(b_out), int'(e_mon.ob));
            check("c_data_out", e_mon.step, int'(c_out), int'(e_mon.oc));
            check("a_count",    e_mon.step, int'(a_cnt), e_mon.ca);
            check("b_count",    e_mon.step, int'(b_cnt), e_mon.cb);
            check("c_count",    e_mon.step, int'(c_cnt), e_mon.cc);
            check("a_sat",      e_mon.step, int'(a_sat), 0);
            check("b_sat",      e_mon.step, int'(b_sat), 0);
            check("c_sat",      e_mon.step, int'(c_sat), int'(e_mon.sc));
        end
    end

    task automatic step(input logic r, input logic e, input logic d,
                        input logic oa, input logic ob, input logic oc,
                        input int ca, input int cb, input int cc, input logic sc);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        din = d;
        step_no++;
        x.step = step_no;
        x.oa = oa; x.ob = ob; x.oc = oc;
        x.ca = ca; x.cb = cb; x.cc = cc;
        x.sc = sc;
        sb_q.push_back(x);
    endtask

    initial begin
        //   rst en d   oa ob oc  ca cb cc sc
        // Reset state
        step(1, 1, 0,  0, 0, 0,  0, 0, 0, 0);
        // 1,0,1,0,1,0: overlap matches bits 4 and 6, non-overlap only bit 4
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 0,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 0,  1, 1, 1,  0, 0, 0, 0);
        step(0, 1, 1,  0, 0, 0,  1, 1, 1, 0);
        step(0, 1, 0,  1, 0, 1,  1, 1, 1, 0);
        step(1, 1, 1,  0, 0, 0,  2, 1, 2, 0);
        // 1,1,0,1,0: failure transition S1 -> S1 on the second 1
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 0,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 0,  1, 1, 1,  0, 0, 0, 0);
        step(1, 1, 1,  0, 0, 0,  1, 1, 1, 0);
        // 1,0,1, reset carrying the completing bit, then 0: no match
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 0,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(1, 1, 0,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 0,  0, 0, 0,  0, 0, 0, 0);
        // 1, three disabled 0s, then 0,1,0: match on the final bit
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 0,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 1,  0, 0, 0,  0, 0, 0, 0);
        step(0, 1, 0,  1, 1, 1,  0, 0, 0, 0);
        // Completing bit held off by enable low while in S3
        step(0, 1, 1,  0, 0, 0,  1, 1, 1, 0);
        step(0, 0, 0,  0, 0, 0,  1, 1, 1, 0);
        step(0, 1, 0,  1, 0, 1,  1, 1, 1, 0);
        // Further overlapping matches: C saturates at 3, flag keeps pulsing
        step(0, 1, 1,  0, 0, 0,  2, 1, 2, 0);
        step(0, 1, 0,  1, 1, 1,  2, 1, 2, 0);
        step(0, 1, 1,  0, 0, 0,  3, 2, 3, 1);
        step(0, 1, 0,  1, 0, 1,  3, 2, 3, 1);
        step(0, 1, 1,  0, 0, 0,  4, 2, 3, 1);
        step(0, 1, 0,  1, 1, 1,  4, 2, 3, 1);
        step(0, 0, 0,  0, 0, 0,  5, 3, 3, 1);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_mealy_seq_detect.md
FSM_MEALY_SEQ_DETECT -- requirements
Module: fsm_mealy_seq_detect

Interface
REQ-001 The block SHALL have parameter PATTERN_WIDTH, default 4, length of the detected bit sequence (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1010, the target sequence, received MSB first.
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 The block SHALL have parameter COUNT_WIDTH, default 8, width of the match counter.
REQ-005 i_clock  input  1  The single clock; all state updates on its rising edge.
REQ-006 i_reset  input  1  Synchronous, active-high reset.
REQ-007 i_enable  input  1  Qualifies i_data_in; the bit is consumed only when this input is high.
REQ-008 i_data_in  input  1  Serial data bit.
REQ-009 o_data_out  output  1  Mealy match flag, combinational from the current state and the current inputs.
REQ-010 o_match_count  output  COUNT_WIDTH  Registered, saturating count of matches.
REQ-011 o_count_sat  output  1  Registered flag, high while o_match_count equals its maximum value.

Function
REQ-012 The FSM SHALL have PATTERN_WIDTH states S0..S(N-1), where Sk means the last k consumed bits equal the first k bits of PATTERN.
REQ-013 On a consumed bit that extends the prefix, the FSM SHALL move from Sk to S(k+1), for k < N-1.
REQ-014 On a consumed mismatching bit, the FSM SHALL move to the longest prefix of PATTERN that is a suffix of the consumed history (KMP failure transition), not unconditionally to S0.
REQ-015 In S(N-1), a consumed bit equal to PATTERN[0] SHALL assert o_data_out in the same cycle, with zero latency.
REQ-016 After a match with OVERLAP=1, the next state SHALL be the longest proper border of PATTERN; with OVERLAP=0, the next state SHALL be S0.
REQ-017 o_data_out SHALL be 0 whenever i_enable=0 or i_reset=1.
REQ-018 When i_enable=0, the state and counter SHALL hold.
REQ-019 Each match SHALL increment o_match_count by 1 on the same clock edge; at all-ones the counter SHALL hold and o_count_sat SHALL be 1.
REQ-020 The transition table SHALL be computed at elaboration from PATTERN; no runtime pattern loading is provided.

Reset
REQ-021 When i_reset=1 at a rising edge, the state SHALL become S0, o_match_count SHALL become 0 and o_count_sat SHALL become 0, overriding i_enable and i_data_in.
REQ-022 Reset asserted mid-sequence SHALL discard partial matches; a sequence can only complete using bits consumed after reset deasserts.

Structure
REQ-023 Package fsm_seq_pkg SHALL hold the state-index type width function (clog2 of PATTERN_WIDTH) and the elaboration-time functions for next-state (prefix/failure) computation.
REQ-024 The match counter SHALL be the sub-module sat_counter (parameter WIDTH; inputs i_clock, i_reset, i_inc; outputs o_count, o_sat).
REQ-025 The RTL SHALL use one registered state variable and a combinational next-state/output block; o_data_out SHALL NOT be registered.

Verification
REQ-026 PATTERN=1010, OVERLAP=1, enable high, stream 1,0,1,0,1,0 -> o_data_out high on bits 4 and 6; o_match_count=2.
REQ-027 Same stream with OVERLAP=0 -> o_data_out high on bit 4 only; o_match_count=1.
REQ-028 PATTERN=1010, stream 1,1,0,1,0 -> single match on bit 5, which checks the failure transition S1 on the second 1.
REQ-029 Stream 1,0,1, then i_reset=1 for one cycle, then 0 -> no match; state S0; count 0.
REQ-030 Stream 1, enable low for 3 cycles with data 0, then 0,1,0 -> match on the final bit; no o_data_out pulse while enable is low.
REQ-031 COUNT_WIDTH=2, five overlapping matches -> o_match_count=3, o_count_sat=1 from the third match onward, with o_data_out still pulsing on every match.
